// File: rtl/assoc_tag_store.sv
// Fully associative tag/data store with a one-deep registered lookup response.
//
// Lookups search every valid entry in the accept cycle and return hit/way/data
// one cycle later over a valid/ready handshake. Fills overwrite a matching
// entry in place, else the lowest-index invalid entry, else the PLRU victim.
// used_o reports the entry touched this cycle so an external plru_tree can
// update its state; plru_i is that tree's one-hot victim.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   flush_i                            invalidate all entries at the next edge
//   lookup_valid_i/ready_o, _tag_i     lookup request handshake and tag
//   resp_valid_o/ready_i               registered response handshake
//   resp_hit_o, resp_way_o, resp_data_o  hit flag, one-hot way, payload (zero on miss)
//   fill_valid_i/ready_o, _tag_i, _data_i  fill request handshake and contents
//   used_o                             one-hot entry touched this cycle
//   plru_i                             one-hot replacement victim
module assoc_tag_store #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned TAG_WIDTH  = 20,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  lookup_valid_i,
    output logic                  lookup_ready_o,
    input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_hit_o,
    output logic [ENTRIES-1:0]    resp_way_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    input  logic                  fill_valid_i,
    output logic                  fill_ready_o,
    input  logic [TAG_WIDTH-1:0]  fill_tag_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    output logic [ENTRIES-1:0]    used_o,
    input  logic [ENTRIES-1:0]    plru_i
);

    typedef enum logic {StEmpty, StFull} resp_state_e;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [ENTRIES];
    logic [DATA_WIDTH-1:0] data_q [ENTRIES];

    resp_state_e           resp_state_q;
    logic                  resp_hit_q;
    logic [ENTRIES-1:0]    resp_way_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    logic [ENTRIES-1:0]    lookup_match;
    logic [ENTRIES-1:0]    fill_match;
    logic [ENTRIES-1:0]    first_invalid;
    logic [ENTRIES-1:0]    fill_target;
    logic [DATA_WIDTH-1:0] lookup_data;
    logic                  invalid_found;
    logic                  lookup_accept;
    logic                  fill_accept;

    // Handshakes: flush blocks everything, fill takes priority over lookup.
    assign fill_ready_o   = !flush_i;
    assign lookup_ready_o = !flush_i && !fill_valid_i &&
                            ((resp_state_q == StEmpty) || resp_ready_i);
    assign fill_accept    = fill_valid_i && fill_ready_o;
    assign lookup_accept  = lookup_valid_i && lookup_ready_o;

    // Tag compare for both request ports, plus the hit payload mux.
    always_comb begin
        lookup_match = '0;
        fill_match   = '0;
        lookup_data  = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            lookup_match[i] = valid_q[i] && (tag_q[i] == lookup_tag_i);
            fill_match[i]   = valid_q[i] && (tag_q[i] == fill_tag_i);
            lookup_data     = lookup_data | (data_q[i] & {DATA_WIDTH{lookup_match[i]}});
        end
    end

    // Lowest-index invalid entry as a one-hot vector.
    always_comb begin
        first_invalid = '0;
        invalid_found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !invalid_found) begin
                first_invalid[i] = 1'b1;
                invalid_found    = 1'b1;
            end
        end
    end

    // Fill target: in-place update keeps tags unique, then free slot, then victim.
    always_comb begin
        if (|fill_match) begin
            fill_target = fill_match;
        end else if (invalid_found) begin
            fill_target = first_invalid;
        end else if ($onehot(plru_i)) begin
            fill_target = plru_i;
        end else begin
            fill_target = {{(ENTRIES-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        if (fill_accept) begin
            used_o = fill_target;
        end else if (lookup_accept) begin
            used_o = lookup_match;
        end else begin
            used_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_accept) begin
            valid_q <= valid_q | fill_target;
        end
    end

    // Tag and data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (fill_accept && fill_target[i]) begin
                tag_q[i]  <= fill_tag_i;
                data_q[i] <= fill_data_i;
            end
        end
    end

    // One-deep response register; contents only change on a new accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_state_q <= StEmpty;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            case (resp_state_q)
                StEmpty: begin
                    if (lookup_accept) begin
                        resp_state_q <= StFull;
                    end
                end
                StFull: begin
                    if (resp_ready_i && !lookup_accept) begin
                        resp_state_q <= StEmpty;
                    end
                end
                default: resp_state_q <= StEmpty;
            endcase
            if (lookup_accept) begin
                resp_hit_q  <= |lookup_match;
                resp_way_q  <= lookup_match;
                resp_data_q <= lookup_data;
            end
        end
    end

    assign resp_valid_o = (resp_state_q == StFull);
    assign resp_hit_o   = resp_hit_q;
    assign resp_way_o   = resp_way_q;
    assign resp_data_o  = resp_data_q;

    // Duplicate tags can only come from a corrupted store.
    lookup_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lookup_accept |-> $onehot0(lookup_match));

    plru_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fill_accept && !(|fill_match) && !invalid_found) |-> $onehot(plru_i));

endmodule

// File: tb/tb_assoc_tag_store.sv
module tb_assoc_tag_store;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          lookup_valid_i;
    logic          lookup_ready_o;
    logic [TW-1:0] lookup_tag_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic          resp_hit_o;
    logic [N-1:0]  resp_way_o;
    logic [DW-1:0] resp_data_o;
    logic          fill_valid_i;
    logic          fill_ready_o;
    logic [TW-1:0] fill_tag_i;
    logic [DW-1:0] fill_data_i;
    logic [N-1:0]  used_o;
    logic [N-1:0]  plru_i;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit            m_valid [N];
    logic [TW-1:0] m_tag   [N];
    logic [DW-1:0] m_data  [N];
    bit            m_rv;
    bit            m_hit;
    int            m_idx;
    logic [DW-1:0] m_rdata;

    assoc_tag_store #(
        .ENTRIES   (N),
        .TAG_WIDTH (TW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .lookup_valid_i(lookup_valid_i),
        .lookup_ready_o(lookup_ready_o),
        .lookup_tag_i  (lookup_tag_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_hit_o    (resp_hit_o),
        .resp_way_o    (resp_way_o),
        .resp_data_o   (resp_data_o),
        .fill_valid_i  (fill_valid_i),
        .fill_ready_o  (fill_ready_o),
        .fill_tag_i    (fill_tag_i),
        .fill_data_i   (fill_data_i),
        .used_o        (used_o),
        .plru_i        (plru_i)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluated 1 time unit before each rising edge: check outputs, then advance.
    task automatic model_step();
        bit lr, fr, la, fa;
        int hit_idx, tgt, exp_used;
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_rv = 0;
            chk("m_reset_resp_valid", 32'(resp_valid_o), 0);
            return;
        end
        fr = !flush_i;
        lr = !flush_i && !fill_valid_i && (!m_rv || resp_ready_i);
        la = lookup_valid_i && lr;
        fa = fill_valid_i && fr;
        hit_idx = -1;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == lookup_tag_i) hit_idx = i;
        tgt = -1;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == fill_tag_i) tgt = i;
        for (int i = 0; i < N; i++)
            if (tgt < 0 && !m_valid[i]) tgt = i;
        for (int i = 0; i < N; i++)
            if (tgt < 0 && plru_i[i]) tgt = i;
        if (fa) exp_used = 1 << tgt;
        else if (la && hit_idx >= 0) exp_used = 1 << hit_idx;
        else exp_used = 0;

        chk("m_fill_ready", 32'(fill_ready_o), 32'(fr));
        chk("m_lookup_ready", 32'(lookup_ready_o), 32'(lr));
        chk("m_used", 32'(used_o), exp_used);
        chk("m_resp_valid", 32'(resp_valid_o), 32'(m_rv));
        if (m_rv) begin
            chk("m_resp_hit", 32'(resp_hit_o), 32'(m_hit));
            chk("m_resp_way", 32'(resp_way_o), m_hit ? (1 << m_idx) : 0);
            chk("m_resp_data", 32'(resp_data_o), 32'(m_rdata));
        end

        if (la) begin
            m_rv    = 1;
            m_hit   = (hit_idx >= 0);
            m_idx   = hit_idx;
            m_rdata = (hit_idx >= 0) ? m_data[hit_idx] : '0;
        end else if (resp_ready_i) begin
            m_rv = 0;
        end
        if (flush_i) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else if (fa) begin
            m_valid[tgt] = 1;
            m_tag[tgt]   = fill_tag_i;
            m_data[tgt]  = fill_data_i;
        end
    endtask

    initial forever begin
        @(negedge clk_i);
        #4;
        model_step();
    end

    task automatic idle();
        flush_i        = 0;
        lookup_valid_i = 0;
        fill_valid_i   = 0;
        resp_ready_i   = 1;
    endtask

    task automatic fill(input logic [TW-1:0] t, input logic [DW-1:0] d);
        lookup_valid_i = 0;
        fill_valid_i   = 1;
        fill_tag_i     = t;
        fill_data_i    = d;
    endtask

    task automatic look(input logic [TW-1:0] t);
        fill_valid_i   = 0;
        lookup_valid_i = 1;
        lookup_tag_i   = t;
    endtask

    initial begin
        rst_ni       = 0;
        idle();
        lookup_tag_i = '0;
        fill_tag_i   = '0;
        fill_data_i  = '0;
        plru_i       = 4'b0001;
        repeat (3) @(negedge clk_i);
        #4;
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        chk("rst_resp_hit", 32'(resp_hit_o), 0);
        chk("rst_resp_way", 32'(resp_way_o), 0);
        chk("rst_resp_data", 32'(resp_data_o), 0);
        chk("rst_used", 32'(used_o), 0);
        @(negedge clk_i) rst_ni = 1;

        // Miss on empty store
        @(negedge clk_i) look(8'h11);
        #4 chk("miss_used", 32'(used_o), 0);
        @(negedge clk_i) idle();
        #4;
        chk("miss_valid", 32'(resp_valid_o), 1);
        chk("miss_hit", 32'(resp_hit_o), 0);
        chk("miss_way", 32'(resp_way_o), 0);

        // Fill all entries in order
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i) fill(8'(8'hA + k), 16'(16'h100 + k));
            #4 chk("fill_order_used", 32'(used_o), 1 << k);
        end
        @(negedge clk_i) look(8'hC);
        #4 chk("hit_c_used", 32'(used_o), 32'h4);
        @(negedge clk_i) idle();
        #4;
        chk("hit_c_way", 32'(resp_way_o), 32'h4);
        chk("hit_c_data", 32'(resp_data_o), 32'h102);

        // Victim replacement
        @(negedge clk_i) begin plru_i = 4'b0010; fill(8'hE, 16'h200); end
        #4 chk("victim_used", 32'(used_o), 32'h2);
        @(negedge clk_i) look(8'hB);
        @(negedge clk_i) look(8'hE);
        #4 chk("evicted_b_hit", 32'(resp_hit_o), 0);
        @(negedge clk_i) idle();
        #4;
        chk("victim_e_way", 32'(resp_way_o), 32'h2);
        chk("victim_e_data", 32'(resp_data_o), 32'h200);

        // In-place overwrite ignores plru_i
        @(negedge clk_i) fill(8'hA, 16'h55);
        #4 chk("inplace_used", 32'(used_o), 32'h1);
        @(negedge clk_i) look(8'hA);
        @(negedge clk_i) idle();
        #4;
        chk("inplace_way", 32'(resp_way_o), 32'h1);
        chk("inplace_data", 32'(resp_data_o), 32'h55);

        // Backpressure holds the response
        @(negedge clk_i) begin look(8'hC); resp_ready_i = 0; end
        @(negedge clk_i) look(8'hD);
        repeat (5) begin
            @(negedge clk_i);
            #4;
            chk("bp_lookup_ready", 32'(lookup_ready_o), 0);
            chk("bp_data_stable", 32'(resp_data_o), 32'h102);
            chk("bp_way_stable", 32'(resp_way_o), 32'h4);
        end
        @(negedge clk_i) resp_ready_i = 1;
        #4 chk("bp_release_ready", 32'(lookup_ready_o), 1);
        @(negedge clk_i) idle();
        #4;
        chk("bp_new_way", 32'(resp_way_o), 32'h8);
        chk("bp_new_data", 32'(resp_data_o), 32'h103);

        // Flush with pending response and colliding fill
        @(negedge clk_i) begin look(8'hC); resp_ready_i = 0; end
        @(negedge clk_i) begin fill(8'h77, 16'h777); flush_i = 1; end
        #4;
        chk("flush_fill_ready", 32'(fill_ready_o), 0);
        chk("flush_used", 32'(used_o), 0);
        @(negedge clk_i) idle();
        #4;
        chk("flush_resp_kept", 32'(resp_valid_o), 1);
        chk("flush_resp_way", 32'(resp_way_o), 32'h4);
        @(negedge clk_i) look(8'hA);
        @(negedge clk_i) idle();
        #4 chk("flush_a_miss", 32'(resp_hit_o), 0);
        @(negedge clk_i) fill(8'h33, 16'h333);
        #4 chk("flush_refill_used", 32'(used_o), 32'h1);
        @(negedge clk_i) idle();

        // Randomized traffic against the model
        repeat (3000) begin
            @(negedge clk_i);
            flush_i        = ($urandom_range(0, 15) == 0);
            fill_valid_i   = ($urandom_range(0, 2) == 0);
            fill_tag_i     = 8'($urandom_range(0, 7));
            fill_data_i    = 16'($urandom);
            lookup_valid_i = ($urandom_range(0, 1) == 1);
            lookup_tag_i   = 8'($urandom_range(0, 7));
            resp_ready_i   = ($urandom_range(0, 3) != 0);
            plru_i         = 4'(1 << $urandom_range(0, 3));
        end
        @(negedge clk_i) idle();

        // Asynchronous reset drops a pending response immediately
        @(negedge clk_i) begin look(8'h33); resp_ready_i = 0; end
        @(negedge clk_i) lookup_valid_i = 0;
        #2 chk("pre_reset_valid", 32'(resp_valid_o), 1);
        rst_ni = 0;
        #1 chk("async_reset_valid", 32'(resp_valid_o), 0);
        @(negedge clk_i) begin rst_ni = 1; idle(); end
        @(negedge clk_i) look(8'h33);
        @(negedge clk_i) idle();
        #4 chk("post_reset_miss", 32'(resp_hit_o), 0);
        repeat (3) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
